// File: rtl/vram_pixel_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : vram_pixel_fetch
//  Description : VGA pixel stage: 128x96 RGB video RAM with a 2-cycle
//                read pipeline, sync realignment, host write port and a
//                full-screen clear engine.
//  Revision    : 1.0 - initial release
// ============================================================================
module vram_pixel_fetch #(
    parameter int HADDR_W = 7,
    parameter int VADDR_W = 7,
    parameter int ROWS    = 96,
    parameter int COLOR_W = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       HSYNC,
    input  logic                       VSYNC,
    input  logic                       haddr_enable,
    input  logic                       vaddr_enable,
    input  logic [HADDR_W-1:0]         pixel_haddr,
    input  logic [VADDR_W-1:0]         pixel_vaddr,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [HADDR_W+VADDR_W-1:0] wr_addr,
    input  logic [COLOR_W-1:0]         wr_data,
    input  logic                       clear_req,
    input  logic [COLOR_W-1:0]         clear_color,
    output logic                       clear_busy,
    output logic                       VGA_RED,
    output logic                       VGA_GREEN,
    output logic                       VGA_BLUE,
    output logic                       VGA_HSYNC,
    output logic                       VGA_VSYNC
);

    localparam int                   c_aw       = HADDR_W + VADDR_W;
    localparam int                   c_depth    = 1 << c_aw;
    localparam logic [VADDR_W:0]     c_rows_ext = (VADDR_W+1)'(ROWS);
    localparam logic [c_aw-1:0]      c_last     = c_aw'(ROWS * (1 << HADDR_W) - 1);
    localparam logic [c_aw-1:0]      c_cnt_one  = c_aw'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    logic [COLOR_W-1:0] mem [0:c_depth-1];

    state_t             r_state;
    logic [c_aw-1:0]    r_clr_cnt;
    logic [COLOR_W-1:0] r_clr_color;
    logic               r_wr_ready;
    logic               r_clear_busy;

    logic [c_aw-1:0]    r_rd_addr;
    logic [COLOR_W-1:0] r_rd_data;
    logic               r_act1, r_act2;
    logic               r_hs1, r_vs1, r_hs2, r_vs2;
    logic [COLOR_W-1:0] r_pixel;
    logic               r_hs_out, r_vs_out;

    logic               w_pix_row_ok;
    logic               w_wr_row_ok;
    logic               w_host_wr;
    logic               w_mem_we;
    logic [c_aw-1:0]    w_mem_waddr;
    logic [COLOR_W-1:0] w_mem_wdata;

    assign w_pix_row_ok = ({1'b0, pixel_vaddr} < c_rows_ext);
    assign w_wr_row_ok  = ({1'b0, wr_addr[c_aw-1:HADDR_W]} < c_rows_ext);

    // Rows beyond the display complete the handshake but never reach memory.
    assign w_host_wr    = wr_valid & r_wr_ready & w_wr_row_ok;

    assign w_mem_we     = ~reset & ((r_state == ST_CLEAR) | w_host_wr);
    assign w_mem_waddr  = (r_state == ST_CLEAR) ? r_clr_cnt   : wr_addr;
    assign w_mem_wdata  = (r_state == ST_CLEAR) ? r_clr_color : wr_data;

    // Non-blocking write/read on the same edge yields old data on collision.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem[w_mem_waddr] <= w_mem_wdata;
        end
        r_rd_data <= mem[r_rd_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_clr_cnt    <= '0;
            r_clr_color  <= '0;
            r_wr_ready   <= 1'b1;
            r_clear_busy <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (clear_req) begin
                        r_state      <= ST_CLEAR;
                        r_clr_color  <= clear_color;
                        r_clr_cnt    <= '0;
                        r_wr_ready   <= 1'b0;
                        r_clear_busy <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (r_clr_cnt == c_last) begin
                        r_state      <= ST_IDLE;
                        r_wr_ready   <= 1'b1;
                        r_clear_busy <= 1'b0;
                    end else begin
                        r_clr_cnt    <= r_clr_cnt + c_cnt_one;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_addr <= '0;
            r_act1    <= 1'b0;
            r_act2    <= 1'b0;
            r_hs1     <= 1'b1;
            r_vs1     <= 1'b1;
            r_hs2     <= 1'b1;
            r_vs2     <= 1'b1;
            r_pixel   <= '0;
            r_hs_out  <= 1'b1;
            r_vs_out  <= 1'b1;
        end else begin
            r_rd_addr <= {pixel_vaddr, pixel_haddr};
            r_act1    <= haddr_enable & vaddr_enable & w_pix_row_ok;
            r_hs1     <= HSYNC;
            r_vs1     <= VSYNC;
            r_act2    <= r_act1;
            r_hs2     <= r_hs1;
            r_vs2     <= r_vs1;
            r_pixel   <= r_act2 ? r_rd_data : '0;
            r_hs_out  <= r_hs2;
            r_vs_out  <= r_vs2;
        end
    end

    assign wr_ready   = r_wr_ready;
    assign clear_busy = r_clear_busy;
    assign VGA_RED    = r_pixel[COLOR_W-1];
    assign VGA_GREEN  = r_pixel[COLOR_W-2];
    assign VGA_BLUE   = r_pixel[0];
    assign VGA_HSYNC  = r_hs_out;
    assign VGA_VSYNC  = r_vs_out;

endmodule
`default_nettype wire

// File: tb/tb_vram_pixel_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vram_pixel_fetch
//  Description : Self-checking bench for vram_pixel_fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_pixel_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        HSYNC, VSYNC;
    logic        haddr_enable, vaddr_enable;
    logic [6:0]  pixel_haddr, pixel_vaddr;
    logic        wr_valid;
    logic        wr_ready;
    logic [13:0] wr_addr;
    logic [2:0]  wr_data;
    logic        clear_req;
    logic [2:0]  clear_color;
    logic        clear_busy;
    logic        VGA_RED, VGA_GREEN, VGA_BLUE, VGA_HSYNC, VGA_VSYNC;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vram_pixel_fetch #(
        .HADDR_W(7), .VADDR_W(7), .ROWS(96), .COLOR_W(3)
    ) dut (
        .clk(clk), .reset(reset), .HSYNC(HSYNC), .VSYNC(VSYNC),
        .haddr_enable(haddr_enable), .vaddr_enable(vaddr_enable),
        .pixel_haddr(pixel_haddr), .pixel_vaddr(pixel_vaddr),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .clear_req(clear_req), .clear_color(clear_color),
        .clear_busy(clear_busy), .VGA_RED(VGA_RED), .VGA_GREEN(VGA_GREEN),
        .VGA_BLUE(VGA_BLUE), .VGA_HSYNC(VGA_HSYNC), .VGA_VSYNC(VGA_VSYNC)
    );

    // Reference model: screen array, clear progress index, and a 2-entry
    // delay line of the pixel/sync values each sampled edge must produce.
    logic [2:0] model_mem [0:16383];
    bit         m_started = 0;
    bit         m_busy    = 0;
    int         m_k       = 0;
    logic [2:0] m_color   = 3'b000;
    logic [4:0] pipe_q[$];
    logic [4:0] m_out     = 5'b00011;

    always @(posedge clk) begin : model
        logic [4:0]  entry;
        logic [13:0] a;
        if (reset) begin
            m_started = 1;
            m_busy    = 0;
            m_out     = 5'b00011;
            pipe_q    = '{5'b00011, 5'b00011};
        end else if (m_started) begin
            if (m_busy) begin
                model_mem[m_k] = m_color;
                m_k++;
                if (m_k == 96 * 128) m_busy = 0;
            end else begin
                if (wr_valid && (wr_addr[13:7] < 7'd96)) model_mem[wr_addr] = wr_data;
                if (clear_req) begin
                    m_busy  = 1;
                    m_k     = 0;
                    m_color = clear_color;
                end
            end
            a     = {pixel_vaddr, pixel_haddr};
            entry = {(haddr_enable && vaddr_enable && pixel_vaddr < 7'd96) ? model_mem[a] : 3'b000,
                     HSYNC, VSYNC};
            m_out = pipe_q.pop_front();
            pipe_q.push_back(entry);
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            logic [6:0] got, exp;
            got = {VGA_RED, VGA_GREEN, VGA_BLUE, VGA_HSYNC, VGA_VSYNC, wr_ready, clear_busy};
            exp = {m_out, ~m_busy, m_busy};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL model_outputs t=%0t got=%b expected=%b", $time, got, exp);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic set_pix(input logic [6:0] v, input logic [6:0] h, input logic en);
        pixel_vaddr  = v;
        pixel_haddr  = h;
        haddr_enable = en;
        vaddr_enable = en;
    endtask

    task automatic read_chk(input string name, input logic [6:0] v, input logic [6:0] h,
                            input logic [2:0] exp);
        set_pix(v, h, 1'b1);
        step(3);
        chk(name, {29'd0, VGA_RED, VGA_GREEN, VGA_BLUE}, {29'd0, exp});
        set_pix(7'd0, 7'd0, 1'b0);
    endtask

    task automatic start_clear(input logic [2:0] col);
        clear_req   = 1'b1;
        clear_color = col;
        step(1);
        clear_req   = 1'b0;
        clear_color = ~col;
    endtask

    task automatic wait_clear(input int start, input int mid, output int cnt);
        cnt = start;
        while (clear_busy === 1'b1 && cnt < 20000) begin
            clear_req = (cnt == mid);
            step(1);
            cnt++;
        end
        clear_req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        reset = 1'b1; HSYNC = 1'b0; VSYNC = 1'b1;
        set_pix(7'd0, 7'd0, 1'b0);
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        clear_req = 1'b0; clear_color = '0;

        // Reset state and sync alignment
        step(2);
        chk("reset_outputs",
            {25'd0, VGA_RED, VGA_GREEN, VGA_BLUE, VGA_HSYNC, VGA_VSYNC, wr_ready, clear_busy},
            {25'd0, 7'b000_11_1_0});
        reset = 1'b0;
        step(2);
        chk("hsync_not_yet", {31'd0, VGA_HSYNC}, 32'd1);
        step(1);
        chk("hsync_latency2", {31'd0, VGA_HSYNC}, 32'd0);
        HSYNC = 1'b1;

        // Host write then display read
        wr_valid = 1'b1; wr_addr = {7'd5, 7'd17}; wr_data = 3'b101;
        step(1);
        wr_valid = 1'b0;
        set_pix(7'd5, 7'd17, 1'b1);
        step(2);
        chk("read_before_latency", {29'd0, VGA_RED, VGA_GREEN, VGA_BLUE}, 32'd0);
        step(1);
        chk("read_5_17", {29'd0, VGA_RED, VGA_GREEN, VGA_BLUE}, 32'b101);
        haddr_enable = 1'b0;
        step(2);
        chk("blank_before_latency", {29'd0, VGA_RED, VGA_GREEN, VGA_BLUE}, 32'b101);
        step(1);
        chk("blank_after_latency", {29'd0, VGA_RED, VGA_GREEN, VGA_BLUE}, 32'd0);
        set_pix(7'd0, 7'd0, 1'b0);

        // Full-screen clear
        start_clear(3'b010);
        wait_clear(0, -1, cnt);
        chk("clear_busy_cycles", cnt, 32'd12288);
        read_chk("clear_0_0",    7'd0,  7'd0,   3'b010);
        read_chk("clear_95_127", 7'd95, 7'd127, 3'b010);
        read_chk("clear_47_64",  7'd47, 7'd64,  3'b010);

        // Host write and clear request on the same idle edge
        wr_valid = 1'b1; wr_addr = {7'd10, 7'd3}; wr_data = 3'b110;
        start_clear(3'b001);
        wr_addr = {7'd11, 7'd4}; wr_data = 3'b011;
        set_pix(7'd10, 7'd3, 1'b1);
        step(3);
        chk("contention_write_done", {29'd0, VGA_RED, VGA_GREEN, VGA_BLUE}, 32'b110);
        wait_clear(3, 100, cnt);
        chk("contention_busy_cycles", cnt, 32'd12288);
        chk("held_write_ready", {31'd0, wr_ready}, 32'd1);
        step(1);
        wr_valid = 1'b0;
        set_pix(7'd0, 7'd0, 1'b0);
        read_chk("held_write_11_4", 7'd11, 7'd4, 3'b011);
        read_chk("cleared_10_3",    7'd10, 7'd3, 3'b001);

        // Out-of-range rows
        wr_valid = 1'b1; wr_addr = {7'd100, 7'd0}; wr_data = 3'b111;
        step(1);
        chk("oor_handshake_ready", {31'd0, wr_ready}, 32'd1);
        wr_valid = 1'b0;
        read_chk("oor_read_row100", 7'd100, 7'd0, 3'b000);
        read_chk("oor_no_alias_4_0", 7'd4,  7'd0, 3'b001);

        // Reset in the middle of a clear
        start_clear(3'b110);
        step(499);
        reset = 1'b1;
        step(1);
        chk("midclear_reset", {30'd0, wr_ready, clear_busy}, 32'b10);
        reset = 1'b0;
        start_clear(3'b111);
        wait_clear(0, -1, cnt);
        chk("after_reset_busy_cycles", cnt, 32'd12288);
        read_chk("reclear_95_127", 7'd95, 7'd127, 3'b111);
        read_chk("reclear_0_0",    7'd0,  7'd0,   3'b111);

        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vram_pixel_fetch.md
Name: vram_pixel_fetch

Overview:
- Pixel-data stage directly downstream of the horizontal and vertical sync controllers.
- Consumes horizontal and vertical pixel addresses, their enables, and HSYNC/VSYNC; reads a 128x96 3-bit (RGB) video RAM.
- Drives VGA colour pins, with sync outputs delayed to stay aligned with colour data.
- Includes a host write port and a full-screen clear engine.

Parameters:
- HADDR_W, 7: horizontal address width (128 pixels per line).
- VADDR_W, 7: vertical address width.
- ROWS, 96: number of valid display rows; rows at or above ROWS display black.
- COLOR_W, 3: bits per pixel, one each for R, G, B.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- HSYNC  in  1  horizontal sync from the hsync controller, active low.
- VSYNC  in  1  vertical sync from the vsync controller, active low.
- haddr_enable  in  1  horizontal address valid (visible region).
- vaddr_enable  in  1  vertical address valid (visible region).
- pixel_haddr  in  HADDR_W  horizontal pixel address.
- pixel_vaddr  in  VADDR_W  vertical pixel address.
- wr_valid  in  1  host write request.
- wr_ready  out  1  host write can be accepted.
- wr_addr  in  HADDR_W+VADDR_W  write address {row, col}.
- wr_data  in  COLOR_W  write pixel {R, G, B}.
- clear_req  in  1  request clear of the whole screen.
- clear_color  in  COLOR_W  fill colour, sampled on clear_req acceptance.
- clear_busy  out  1  clear in progress.
- VGA_RED  out  1  red output.
- VGA_GREEN  out  1  green output.
- VGA_BLUE  out  1  blue output.
- VGA_HSYNC  out  1  delayed HSYNC.
- VGA_VSYNC  out  1  delayed VSYNC.

Behaviour:
- Reset is synchronous, active-high, single clock clk.
- Reset values: VGA_RED, VGA_GREEN, VGA_BLUE = 0; VGA_HSYNC = VGA_VSYNC = 1; wr_ready = 1; clear_busy = 0; clear FSM in IDLE; clear counter = 0. All pipeline sync registers reset to 1; all active flags reset to 0.
- RAM contents are not reset.
- Memory: 2^(HADDR_W+VADDR_W) x COLOR_W words. Address = {vaddr, haddr}; no multiply.
- Memory has one registered read port and one write port. Read-during-write to the same address returns the old data.
- Read pipeline, fixed latency 2 cycles from sampled inputs to pins:
  - S1 (edge N): rd_addr <= {pixel_vaddr, pixel_haddr}; act1 <= haddr_enable & vaddr_enable & (pixel_vaddr < ROWS); hs1/vs1 <= HSYNC/VSYNC.
  - S2 (edge N+1): rd_data <= mem[rd_addr]; act2 <= act1; hs2/vs2 <= hs1/vs1.
  - Out (edge N+2): {VGA_RED, VGA_GREEN, VGA_BLUE} <= act2 ? rd_data : 0; VGA_HSYNC/VSYNC <= hs2/vs2.
- Colour outputs are forced to 0 whenever either enable is low at sampling, so blanking is exact.
- Clear FSM:
  - IDLE: wr_ready = 1, clear_busy = 0.
  - IDLE -> CLEAR on clear_req = 1. On that edge: latch clear_color, set counter = 0.
  - CLEAR: wr_ready = 0, clear_busy = 1. Each cycle writes mem[counter] <= latched colour, then counter++.
  - Counter runs linearly over {row, col}, from 0 to ROWS*2^HADDR_W - 1 (12287 at defaults).
  - After writing the last address, return to IDLE. clear_busy is high for exactly ROWS*2^HADDR_W cycles (12288 at defaults).
  - clear_req during CLEAR is ignored; no restart and no queueing.
- Host write: accepted on an edge where wr_valid & wr_ready.
  - wr_addr with row >= ROWS is accepted (handshake completes) but the write is dropped.
  - wr_valid while wr_ready = 0 is held off; the host must hold wr_valid and its data stable until accepted.
- Simultaneous wr_valid and clear_req in IDLE: the host write is performed on that edge, and CLEAR starts on the same edge (first clear write on the next edge).
- The display read path runs unaffected during CLEAR and during host writes.
- Reset mid-CLEAR: FSM returns to IDLE and clear_busy drops on that edge. Memory stays partially cleared.
- No address wrap hazards: the counter stops at the last address and never wraps into the unused rows.

Test Plan:
- Reset alignment: assert reset 2 cycles with HSYNC = 0 at input -> RGB = 0, VGA_HSYNC = VGA_VSYNC = 1, wr_ready = 1, clear_busy = 0. After release, HSYNC = 0 appears on VGA_HSYNC exactly 2 cycles later.
- Write/read: write 3'b101 to {row 5, col 17}; drive vaddr = 5, haddr = 17 with both enables high -> RGB = 1,0,1 exactly 2 cycles later. Dropping haddr_enable -> RGB = 0, 2 cycles later.
- Clear: pulse clear_req with clear_color = 3'b010 -> clear_busy high for exactly 12288 cycles and wr_ready low for the same window. Afterwards, addresses {0,0}, {95,127} and {47,64} read 3'b010.
- Clear contention: assert wr_valid with clear_req in the same IDLE cycle -> the write completes. Then wr_valid held high during CLEAR -> wr_ready = 0 until CLEAR ends, and the write is accepted in the first IDLE cycle. clear_req mid-clear -> clear_busy duration unchanged.
- Out-of-range rows: write to row 100 -> handshake completes, memory unchanged. Read at vaddr = 100 with both enables high -> RGB = 0.
- Reset mid-clear: reset at clear cycle 500 -> clear_busy = 0 and wr_ready = 1 the next cycle; a new clear_req runs the full 12288 cycles.
